// File: rtl/sensor_adc_acq_if.sv
// Sample stream from the ADC acquisition front-end: 8-bit sample, channel tag,
// valid/ready handshake.
interface sensor_adc_acq_if;
  logic [7:0] sample_data;
  logic       sample_ch;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_data,
    output sample_ch,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_ch,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/sensor_adc_acq.sv
// Dual-channel SPI ADC acquisition (MCP3002-style framing, SPI mode 0).
// Alternates channels, truncates 10-bit results to 8 bits, offers them on a valid/ready stream.
module sensor_adc_acq #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_GAP = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start_en,
  input  logic              adc_miso,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic              adc_mosi,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr,
  sensor_adc_acq_if.master  smp
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    GAP      = 3'd4
  } state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(SAMPLE_GAP - 1);
  localparam logic [4:0]  HALF_LAST = 5'd31;
  localparam logic [3:0]  MISO_FIRST = 4'd5;
  localparam logic [3:0]  MISO_LAST  = 4'd14;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  div_cnt;
  logic [4:0]  half_cnt;
  logic [15:0] gap_cnt;
  logic [9:0]  shift_reg;
  logic        next_ch;

  logic        div_done;
  logic        gap_done;
  logic        half_last;
  logic        sclk_edge;
  logic        rise_edge;
  logic        fall_edge;
  logic [3:0]  rise_idx;
  logic        capture;
  logic        offer;
  logic        enter_setup;
  logic        accept;
  logic        drop;
  logic        xfer;

  // Command bit presented ahead of rising edge k: start, single-ended, channel, MSB-first.
  function automatic logic cmd_bit(input logic [4:0] k, input logic ch);
    logic b;
    case (k)
      5'd0, 5'd1, 5'd3: b = 1'b1;
      5'd2:             b = ch;
      default:          b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] trunc_result(input logic [9:0] res);
    return res[9:2];
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    offer       = 1'b0;
    div_done    = (div_cnt == DIV_LAST);
    gap_done    = (gap_cnt == GAP_LAST);
    half_last   = (half_cnt == HALF_LAST);
    sclk_edge   = (state == SHIFT) && div_done;
    rise_edge   = sclk_edge && !half_cnt[0];
    fall_edge   = sclk_edge && half_cnt[0];
    rise_idx    = half_cnt[4:1];
    capture     = rise_edge && (rise_idx >= MISO_FIRST) && (rise_idx <= MISO_LAST);

    case (state)
      IDLE: begin
        if (start_en) state_nxt = CS_SETUP;
      end
      CS_SETUP: begin
        if (div_done) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (div_done && half_last) state_nxt = CS_HOLD;
      end
      CS_HOLD: begin
        if (div_done) begin
          offer     = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_done) state_nxt = start_en ? CS_SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    enter_setup = (state_nxt == CS_SETUP) && (state != CS_SETUP);
    accept      = offer && (!smp.sample_valid || smp.sample_ready);
    drop        = offer && smp.sample_valid && !smp.sample_ready;
    xfer        = smp.sample_valid && smp.sample_ready;
  end

  // Prescaler, half-period and gap counters; each is cleared when its phase ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
    end else if (ena) begin
      if ((state_nxt != state) || div_done || (state == IDLE) || (state == GAP)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (state != SHIFT) begin
        half_cnt <= '0;
      end else if (div_done) begin
        half_cnt <= half_last ? 5'd0 : half_cnt + 5'd1;
      end

      if ((state != GAP) || gap_done) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

  // SPI pins and receive shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      adc_mosi  <= 1'b0;
      shift_reg <= '0;
      next_ch   <= 1'b0;
    end else if (ena) begin
      if (enter_setup) begin
        adc_cs_n <= 1'b0;
      end else if (offer) begin
        adc_cs_n <= 1'b1;
      end

      if (sclk_edge) begin
        adc_sclk <= ~half_cnt[0];
      end else if (state != SHIFT) begin
        adc_sclk <= 1'b0;
      end

      if ((state == CS_SETUP) && div_done) begin
        adc_mosi <= cmd_bit(5'd0, next_ch);
      end else if (fall_edge) begin
        adc_mosi <= cmd_bit({1'b0, rise_idx} + 5'd1, next_ch);
      end

      if (capture) begin
        shift_reg <= {shift_reg[8:0], adc_miso};
      end

      if (offer) begin
        next_ch <= ~next_ch;
      end
    end
  end

  // Output stage: a held, unaccepted sample is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp.sample_data  <= '0;
      smp.sample_ch    <= 1'b0;
      smp.sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        smp.sample_data  <= trunc_result(shift_reg);
        smp.sample_ch    <= next_ch;
        smp.sample_valid <= 1'b1;
      end else if (xfer) begin
        smp.sample_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
